// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: one-outstanding-request fetch FSM feeding a DEPTH-entry FIFO.
// Define FETCH_QUEUE_BYPASS_EN to let an empty queue forward returning data in the ack cycle.
module instr_fetch_queue #(
   parameter int              XLEN     = 32,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            reset,
   output logic            fetch_req,
   output logic [XLEN-1:0] fetch_addr,
   input  logic            fetch_ack,
   input  logic [XLEN-1:0] fetch_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_instr,
   output logic [XLEN-1:0] out_pc
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

   state_t          r_state;
   state_t          w_nextState;
   logic [XLEN-1:0] r_fetchPc;
   logic [XLEN-1:0] r_reqAddr;
   logic [PW-1:0]   r_rdPtr;
   logic [PW-1:0]   r_wrPtr;
   logic [CW-1:0]   r_count;
   logic [XLEN-1:0] r_instrMem [DEPTH];
   logic [XLEN-1:0] r_pcMem    [DEPTH];

   logic w_empty;
   logic w_notFull;
   logic w_issue;
   logic w_ackLive;
   logic w_bypass;
   logic w_push;
   logic w_pop;

   assign w_empty   = (r_count == '0);
   assign w_notFull = (r_count < CW'(DEPTH));
   assign w_issue   = (r_state == IDLE) && w_notFull && !redirect_valid;
   // Only an ack to a live (non-flushed) request carries an instruction we keep.
   assign w_ackLive = (r_state == WAIT) && fetch_ack && !redirect_valid;

`ifdef FETCH_QUEUE_BYPASS_EN
   assign w_bypass = w_ackLive && w_empty;
`else
   assign w_bypass = 1'b0;
`endif

   assign w_pop  = !w_empty && out_ready && !redirect_valid;
   assign w_push = w_ackLive && !(w_bypass && out_ready);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE: begin
            if (w_issue) begin
               w_nextState = WAIT;
            end
         end
         WAIT: begin
            if (fetch_ack) begin
               w_nextState = IDLE;
            end else if (redirect_valid) begin
               w_nextState = DRAIN;
            end
         end
         DRAIN: begin
            // A redirect here only retargets fetch_pc; the old response must still drain.
            if (fetch_ack) begin
               w_nextState = IDLE;
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

   always_comb begin
      fetch_req  = 1'b0;
      fetch_addr = r_fetchPc;
      case (r_state)
         IDLE: begin
            fetch_req = w_issue && !reset;
         end
         WAIT, DRAIN: begin
            fetch_req  = 1'b1;
            fetch_addr = r_reqAddr;
         end
         default: begin
            fetch_req = 1'b0;
         end
      endcase

      out_valid = !w_empty || w_bypass;
      out_instr = '0;
      out_pc    = '0;
      if (!w_empty) begin
         out_instr = r_instrMem[r_rdPtr];
         out_pc    = r_pcMem[r_rdPtr];
      end else if (w_bypass) begin
         out_instr = fetch_data;
         out_pc    = r_reqAddr;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_fetchPc <= RESET_PC;
         r_reqAddr <= RESET_PC;
      end else begin
         if (redirect_valid) begin
            r_fetchPc <= redirect_pc & ~XLEN'(3);
         end else if (w_ackLive) begin
            r_fetchPc <= r_reqAddr + XLEN'(4);
         end
         if (w_issue) begin
            r_reqAddr <= r_fetchPc;
         end
      end
   end

   // Flush wins over any same-cycle push or pop.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rdPtr <= '0;
         r_wrPtr <= '0;
         r_count <= '0;
      end else if (redirect_valid) begin
         r_rdPtr <= '0;
         r_wrPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wrPtr <= r_wrPtr + PW'(1);
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + PW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_instrMem[r_wrPtr] <= fetch_data;
         r_pcMem[r_wrPtr]    <= r_reqAddr;
      end
   end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue: directed scenarios plus randomized traffic
// compared every cycle against a queue-based reference model.
module tb_instr_fetch_queue;

   localparam int          XLEN     = 32;
   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        fetch_req;
   logic [31:0] fetch_addr;
   logic        fetch_ack = 1'b0;
   logic [31:0] fetch_data = '0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_instr;
   logic [31:0] out_pc;

   int nCompared   = 0;
   int nMismatched = 0;
   int cycleCount  = 0;

   instr_fetch_queue #(
      .XLEN     (XLEN),
      .DEPTH    (DEPTH),
      .RESET_PC (RESET_PC)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .fetch_req      (fetch_req),
      .fetch_addr     (fetch_addr),
      .fetch_ack      (fetch_ack),
      .fetch_data     (fetch_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycleCount <= cycleCount + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      nCompared++;
      if (actual !== expected) begin
         nMismatched++;
         $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cycleCount);
      end
   endtask

   task automatic applyStimulus(input bit rst, input bit rdy, input bit rv, input logic [31:0] rpc);
      @(posedge clk);
      #1;
      reset          = rst;
      out_ready      = rdy;
      redirect_valid = rv;
      redirect_pc    = rpc;
   endtask

   function automatic logic [31:0] wordAt(input logic [31:0] addr);
      return (addr * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
   endfunction

   // Memory responder: acks a request once it has been visible for memLat cycles.
   bit memEnable  = 1'b0;
   bit memRandLat = 1'b0;
   bit spurious   = 1'b0;
   int memLat     = 1;
   int reqAge     = 0;

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (reset || !memEnable) begin
            fetch_ack = 1'b0;
         end else if (reqAge >= memLat) begin
            fetch_ack  = 1'b1;
            fetch_data = wordAt(fetch_addr);
            if (memRandLat) memLat = $urandom_range(1, 3);
         end else if (spurious && reqAge == 0 && $urandom_range(0, 9) == 0) begin
            fetch_ack  = 1'b1;
            fetch_data = 32'hDEAD_0000 ^ $urandom;
         end else begin
            fetch_ack = 1'b0;
         end
         @(negedge clk);
         if (reset || fetch_ack || !fetch_req) reqAge = 0;
         else reqAge++;
      end
   end

   // Reference model: a plain queue of {pc, instr} plus the one outstanding request.
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } entry_t;

   entry_t      mQ[$];
   logic [31:0] mPc      = RESET_PC;
   logic [31:0] mReqAddr = RESET_PC;
   bit          mPend    = 1'b0;
   bit          mStale   = 1'b0;
   bit          mIssue;
   bit          mPop;
   bit          mByp;
   entry_t      mEntry;

   function automatic bit bypassNow();
`ifdef FETCH_QUEUE_BYPASS_EN
      return (mQ.size() == 0) && mPend && !mStale && fetch_ack && !redirect_valid;
`else
      return 1'b0;
`endif
   endfunction

   function automatic bit expReq();
      return !reset && (mPend || ((mQ.size() < DEPTH) && !redirect_valid));
   endfunction

   function automatic logic [31:0] expAddr();
      return mPend ? mReqAddr : mPc;
   endfunction

   function automatic bit expValid();
      return (mQ.size() != 0) || bypassNow();
   endfunction

   function automatic entry_t expHead();
      entry_t e;
      e = '0;
      if (mQ.size() != 0) begin
         e = mQ[0];
      end else if (bypassNow()) begin
         e.pc    = mReqAddr;
         e.instr = fetch_data;
      end
      return e;
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         mQ.delete();
         mPc    = RESET_PC;
         mPend  = 1'b0;
         mStale = 1'b0;
      end else begin
         mIssue = !mPend && expReq();
         mByp   = bypassNow();
         mPop   = expValid() && out_ready;
         if (redirect_valid) begin
            mQ.delete();
            if (mPend && fetch_ack) begin
               mPend  = 1'b0;
               mStale = 1'b0;
            end else if (mPend) begin
               mStale = 1'b1;
            end
            mPc = redirect_pc & 32'hFFFF_FFFC;
         end else begin
            if (mPop && !mByp) void'(mQ.pop_front());
            if (mPend && fetch_ack) begin
               if (!mStale) begin
                  mPc = mReqAddr + 32'd4;
                  if (!(mByp && out_ready)) begin
                     mEntry.pc    = mReqAddr;
                     mEntry.instr = fetch_data;
                     mQ.push_back(mEntry);
                  end
               end
               mPend  = 1'b0;
               mStale = 1'b0;
            end
            if (mIssue) begin
               mPend    = 1'b1;
               mStale   = 1'b0;
               mReqAddr = mPc;
            end
         end
      end
   end

   // Every-cycle comparison of the DUT against the model.
   always @(negedge clk) begin : compareProc
      entry_t h;
      if (reset) begin
         checkOutput("rst_fetch_req", 32'(fetch_req), 32'd0);
         checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
         checkOutput("rst_out_pc", out_pc, 32'd0);
         checkOutput("rst_out_instr", out_instr, 32'd0);
      end else begin
         checkOutput("fetch_req", 32'(fetch_req), 32'(expReq()));
         if (expReq()) checkOutput("fetch_addr", fetch_addr, expAddr());
         checkOutput("out_valid", 32'(out_valid), 32'(expValid()));
         if (expValid()) begin
            h = expHead();
            checkOutput("out_pc", out_pc, h.pc);
            checkOutput("out_instr", out_instr, h.instr);
         end
      end
   end

   logic [31:0] poppedPcs[$];
   int          popCycles[$];

   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         poppedPcs.push_back(out_pc);
         popCycles.push_back(cycleCount);
      end
   end

   function automatic logic [31:0] poppedAt(input int i);
      return (i < poppedPcs.size()) ? poppedPcs[i] : 32'hDEAD_BEEF;
   endfunction

   initial begin
      // Reset state
      applyStimulus(1, 0, 0, 0);
      @(negedge clk);
      checkOutput("reset_fetch_req", 32'(fetch_req), 32'd0);
      checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
      checkOutput("reset_out_pc", out_pc, 32'd0);

      // Back-to-back fetches with single-cycle memory and an always-ready consumer
      memEnable = 1'b1;
      memLat    = 1;
      poppedPcs.delete();
      popCycles.delete();
      applyStimulus(0, 1, 0, 0);
      @(negedge clk);
      checkOutput("first_req", 32'(fetch_req), 32'd1);
      checkOutput("first_addr", fetch_addr, 32'h100);
      repeat (7) applyStimulus(0, 1, 0, 0);
      @(negedge clk);
      checkOutput("seq_pc0", poppedAt(0), 32'h100);
      checkOutput("seq_pc1", poppedAt(1), 32'h104);
      checkOutput("seq_pc2", poppedAt(2), 32'h108);
      checkOutput("seq_spacing", (popCycles.size() >= 2) ? 32'(popCycles[1] - popCycles[0]) : 32'hFFFF_FFFF, 32'd2);

      // Stalled consumer fills the queue, then drains and fetching resumes
      applyStimulus(1, 0, 0, 0);
      applyStimulus(1, 0, 0, 0);
      applyStimulus(0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0);
      @(negedge clk);
`ifdef FETCH_QUEUE_BYPASS_EN
      checkOutput("bypass_valid", 32'(out_valid), 32'd1);
      checkOutput("bypass_pc", out_pc, 32'h100);
`else
      checkOutput("no_bypass_valid", 32'(out_valid), 32'd0);
`endif
      repeat (11) applyStimulus(0, 0, 0, 0);
      @(negedge clk);
      checkOutput("full_no_req", 32'(fetch_req), 32'd0);
      checkOutput("full_valid", 32'(out_valid), 32'd1);
      checkOutput("full_head_pc", out_pc, 32'h100);
      checkOutput("model_count", 32'(mQ.size()), 32'd4);
      poppedPcs.delete();
      repeat (12) applyStimulus(0, 1, 0, 0);
      @(negedge clk);
      checkOutput("drain_pc0", poppedAt(0), 32'h100);
      checkOutput("drain_pc1", poppedAt(1), 32'h104);
      checkOutput("drain_pc2", poppedAt(2), 32'h108);
      checkOutput("drain_pc3", poppedAt(3), 32'h10C);
      checkOutput("resume_pc", poppedAt(4), 32'h110);

      // Redirect while a request is outstanding; its late ack is thrown away
      memLat = 3;
      applyStimulus(1, 1, 0, 0);
      applyStimulus(1, 1, 0, 0);
      poppedPcs.delete();
      applyStimulus(0, 1, 0, 0);
      applyStimulus(0, 1, 1, 32'h203);
      applyStimulus(0, 1, 0, 0);
      @(negedge clk);
      checkOutput("drain_req", 32'(fetch_req), 32'd1);
      checkOutput("drain_addr", fetch_addr, 32'h100);
      applyStimulus(0, 1, 0, 0);
      applyStimulus(0, 1, 0, 0);
      @(negedge clk);
      checkOutput("redir_req", 32'(fetch_req), 32'd1);
      checkOutput("redir_addr", fetch_addr, 32'h200);
      repeat (6) applyStimulus(0, 1, 0, 0);
      @(negedge clk);
      checkOutput("redir_first_pc", poppedAt(0), 32'h200);

      // Redirect together with an ack and a pop
      memLat = 1;
      applyStimulus(1, 0, 0, 0);
      applyStimulus(1, 0, 0, 0);
      applyStimulus(0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0);
      applyStimulus(0, 1, 1, 32'h300);
      @(negedge clk);
      checkOutput("coinc_valid_before", 32'(out_valid), 32'd1);
      applyStimulus(0, 1, 0, 0);
      @(negedge clk);
      checkOutput("coinc_flushed", 32'(out_valid), 32'd0);
      checkOutput("coinc_req", 32'(fetch_req), 32'd1);
      checkOutput("coinc_addr", fetch_addr, 32'h300);
      repeat (4) applyStimulus(0, 1, 0, 0);

      // Address wrap at the top of the address space
      applyStimulus(1, 1, 0, 0);
      applyStimulus(1, 1, 0, 0);
      applyStimulus(0, 1, 1, 32'hFFFF_FFFE);
      @(negedge clk);
      checkOutput("wrap_no_req", 32'(fetch_req), 32'd0);
      applyStimulus(0, 1, 0, 0);
      @(negedge clk);
      checkOutput("wrap_top_addr", fetch_addr, 32'hFFFF_FFFC);
      applyStimulus(0, 1, 0, 0);
      applyStimulus(0, 1, 0, 0);
      @(negedge clk);
      checkOutput("wrap_req", 32'(fetch_req), 32'd1);
      checkOutput("wrap_addr", fetch_addr, 32'h0);
      repeat (3) applyStimulus(0, 1, 0, 0);

      // Reset in the middle of an outstanding request with two entries queued
      applyStimulus(1, 0, 0, 0);
      applyStimulus(1, 0, 0, 0);
      repeat (5) applyStimulus(0, 0, 0, 0);
      @(negedge clk);
      checkOutput("pre_rst_count", 32'(mQ.size()), 32'd2);
      checkOutput("pre_rst_req", 32'(fetch_req), 32'd1);
      applyStimulus(1, 0, 0, 0);
      @(negedge clk);
      checkOutput("mid_rst_valid", 32'(out_valid), 32'd0);
      checkOutput("mid_rst_req", 32'(fetch_req), 32'd0);
      applyStimulus(1, 0, 0, 0);
      applyStimulus(0, 0, 0, 0);
      @(negedge clk);
      checkOutput("post_rst_req", 32'(fetch_req), 32'd1);
      checkOutput("post_rst_addr", fetch_addr, RESET_PC);

      // Randomized traffic: variable latency, stray acks, redirects, one reset pulse
      memRandLat = 1'b1;
      spurious   = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] rpc;
         rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
         applyStimulus(i == 1500, $urandom_range(0, 9) < 7, $urandom_range(0, 24) == 0, rpc);
      end
      applyStimulus(1, 0, 0, 0);
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
